// File: rtl/tdc_hist_ctrl.sv
// TDC histogram sequencer: clears the bin BRAM, accumulates decoder hits through a
// forwarding read-modify-write pipeline, drains it, then streams the bins out.
module tdc_hist_ctrl #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 32,
    parameter int ACQ_CYCLES = 1000
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              bin_valid,
    input  logic [ADDR_W-1:0] bin_addr,
    output logic              ra_en,
    output logic [ADDR_W-1:0] ra_addr,
    input  logic [DATA_W-1:0] ra_dout,
    output logic              wb_en,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_din,
    output logic              busy,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              overflow
);

    localparam int NBINS  = 1 << ADDR_W;
    localparam int ACQ_CW = $clog2(ACQ_CYCLES + 1);
    localparam int CNT_W  = (ACQ_CW > ADDR_W + 1) ? ACQ_CW : ADDR_W + 1;

    localparam logic [CNT_W-1:0] BIN_LAST = CNT_W'(NBINS - 1);
    localparam logic [CNT_W-1:0] RD_END   = CNT_W'(NBINS);
    localparam logic [CNT_W-1:0] ACQ_LAST = CNT_W'(ACQ_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ACQ     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_READOUT = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    // Saturating increment; MSB flags that the input was already at full scale.
    function automatic logic [DATA_W:0] sat_inc(input logic [DATA_W-1:0] v);
        logic [DATA_W:0] r;
        if (v == {DATA_W{1'b1}}) begin
            r = {1'b1, v};
        end else begin
            r = {1'b0, v + DATA_W'(1)};
        end
        return r;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              aborted_r;
    logic              wv_r;
    logic              wclr_r;
    logic [ADDR_W-1:0] waddr_r;
    logic              fwd_r;
    logic [DATA_W-1:0] fwd_data_r;
    logic              rd_pend_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              done_r;
    logic              overflow_r;

    logic              acq_hit_s;
    logic              rd_rd_s;
    logic [DATA_W-1:0] base_s;
    logic [DATA_W:0]   sat_s;
    logic [DATA_W-1:0] wdata_s;

    // Port A request decode and increment datapath (base selection with forwarding).
    always_comb begin
        acq_hit_s = 1'b0;
        rd_rd_s   = 1'b0;
        base_s    = ra_dout;
        wdata_s   = {DATA_W{1'b0}};
        if (reset && (state_r == ST_ACQ) && bin_valid && !abort) begin
            acq_hit_s = 1'b1;
        end else begin
            acq_hit_s = 1'b0;
        end
        if (reset && (state_r == ST_READOUT) && (cnt_r < RD_END)) begin
            rd_rd_s = 1'b1;
        end else begin
            rd_rd_s = 1'b0;
        end
        // A write in the hit cycle lands after the BRAM read, so its data is taken directly.
        if (fwd_r) begin
            base_s = fwd_data_r;
        end else begin
            base_s = ra_dout;
        end
        sat_s = sat_inc(base_s);
        if (!wv_r) begin
            wdata_s = {DATA_W{1'b0}};
        end else if (wclr_r) begin
            wdata_s = {DATA_W{1'b0}};
        end else begin
            wdata_s = sat_s[DATA_W-1:0];
        end
    end

    // Phase sequencer plus write/readout pipeline registers.
    always_ff @(posedge clk100) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            aborted_r  <= 1'b0;
            wv_r       <= 1'b0;
            wclr_r     <= 1'b0;
            waddr_r    <= {ADDR_W{1'b0}};
            fwd_r      <= 1'b0;
            fwd_data_r <= {DATA_W{1'b0}};
            rd_pend_r  <= 1'b0;
            rd_addr_r  <= {ADDR_W{1'b0}};
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wv_r       <= acq_hit_s;
            wclr_r     <= 1'b0;
            waddr_r    <= acq_hit_s ? bin_addr : {ADDR_W{1'b0}};
            fwd_r      <= acq_hit_s && wv_r && (waddr_r == bin_addr);
            fwd_data_r <= wdata_s;
            rd_pend_r  <= rd_rd_s;
            if (rd_rd_s) begin
                rd_addr_r <= cnt_r[ADDR_W-1:0];
            end
            done_r <= 1'b0;
            if (wv_r && !wclr_r && sat_s[DATA_W]) begin
                overflow_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_CLEAR;
                        cnt_r      <= {CNT_W{1'b0}};
                        aborted_r  <= 1'b0;
                        overflow_r <= 1'b0;
                        wv_r       <= 1'b1;
                        wclr_r     <= 1'b1;
                        waddr_r    <= {ADDR_W{1'b0}};
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == BIN_LAST) begin
                        state_r <= ST_ACQ;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        wv_r    <= 1'b1;
                        wclr_r  <= 1'b1;
                        waddr_r <= cnt_r[ADDR_W-1:0] + ADDR_W'(1);
                    end
                end
                ST_ACQ: begin
                    if (abort) begin
                        state_r   <= ST_DRAIN;
                        aborted_r <= 1'b1;
                    end else if (cnt_r == ACQ_LAST) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (abort || aborted_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_READOUT;
                    end
                end
                ST_READOUT: begin
                    if (abort) begin
                        state_r   <= ST_IDLE;
                        rd_pend_r <= 1'b0;
                    end else if (cnt_r == RD_END) begin
                        state_r <= ST_FIN;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ra_en    = acq_hit_s | rd_rd_s;
    assign ra_addr  = acq_hit_s ? bin_addr : (rd_rd_s ? cnt_r[ADDR_W-1:0] : {ADDR_W{1'b0}});
    assign wb_en    = wv_r;
    assign wb_we    = wv_r;
    assign wb_addr  = waddr_r;
    assign wb_din   = wdata_s;
    assign busy     = (state_r != ST_IDLE);
    assign rd_valid = rd_pend_r;
    assign rd_addr  = rd_addr_r;
    assign rd_data  = rd_pend_r ? ra_dout : {DATA_W{1'b0}};
    assign done     = done_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_tdc_hist_ctrl.sv
// Directed bench for tdc_hist_ctrl: two instances (32-bit and 4-bit bins), each with
// a read-first BRAM model; expectations are hand-computed constants.
module tb_tdc_hist_ctrl;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       start_b = 1'b0;
    logic       abort = 1'b0;
    logic       bin_valid = 1'b0;
    logic [1:0] bin_addr = 2'd0;

    logic        ra_en_a, wb_en_a, wb_we_a, busy_a, rd_valid_a, done_a, overflow_a;
    logic [1:0]  ra_addr_a, wb_addr_a, rd_addr_a;
    logic [31:0] ra_dout_a, wb_din_a, rd_data_a;

    logic       ra_en_b, wb_en_b, wb_we_b, busy_b, rd_valid_b, done_b, overflow_b;
    logic [1:0] ra_addr_b, wb_addr_b, rd_addr_b;
    logic [3:0] ra_dout_b, wb_din_b, rd_data_b;

    logic [31:0] mem_a [4] = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004};
    logic [3:0]  mem_b [4] = '{4'h9, 4'h5, 4'hA, 4'h3};

    tdc_hist_ctrl #(.ADDR_W(2), .DATA_W(32), .ACQ_CYCLES(8)) dut (
        .clk100(clk100), .reset(reset), .start(start), .abort(abort),
        .bin_valid(bin_valid), .bin_addr(bin_addr),
        .ra_en(ra_en_a), .ra_addr(ra_addr_a), .ra_dout(ra_dout_a),
        .wb_en(wb_en_a), .wb_we(wb_we_a), .wb_addr(wb_addr_a), .wb_din(wb_din_a),
        .busy(busy_a), .rd_valid(rd_valid_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .done(done_a), .overflow(overflow_a)
    );

    tdc_hist_ctrl #(.ADDR_W(2), .DATA_W(4), .ACQ_CYCLES(24)) dut_b (
        .clk100(clk100), .reset(reset), .start(start_b), .abort(abort),
        .bin_valid(bin_valid), .bin_addr(bin_addr),
        .ra_en(ra_en_b), .ra_addr(ra_addr_b), .ra_dout(ra_dout_b),
        .wb_en(wb_en_b), .wb_we(wb_we_b), .wb_addr(wb_addr_b), .wb_din(wb_din_b),
        .busy(busy_b), .rd_valid(rd_valid_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .done(done_b), .overflow(overflow_b)
    );

    // Read-first dual-port BRAM models.
    always @(posedge clk100) begin
        if (ra_en_a) ra_dout_a <= mem_a[ra_addr_a];
        if (wb_en_a && wb_we_a) mem_a[wb_addr_a] <= wb_din_a;
        if (ra_en_b) ra_dout_b <= mem_b[ra_addr_b];
        if (wb_en_b && wb_we_b) mem_b[wb_addr_b] <= wb_din_b;
    end

    int cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    int          wr_n = 0, rd_n = 0, done_n = 0, done_cyc = 0, rd_last_cyc = 0;
    logic [1:0]  rd_addr_log [64];
    logic [31:0] rd_data_log [64];
    int          rdb_n = 0, doneb_n = 0;
    logic [3:0]  rdb_data [4];

    // Output monitors, sampled on the falling edge.
    always @(negedge clk100) begin
        if (wb_en_a && wb_we_a) wr_n <= wr_n + 1;
        if (rd_valid_a) begin
            rd_addr_log[rd_n % 64] <= rd_addr_a;
            rd_data_log[rd_n % 64] <= rd_data_a;
            rd_last_cyc <= cyc;
            rd_n <= rd_n + 1;
        end
        if (done_a) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (rd_valid_b) begin
            rdb_data[rd_addr_b] <= rd_data_b;
            rdb_n <= rdb_n + 1;
        end
        if (done_b) doneb_n <= doneb_n + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int wr_base, rd_base, done_base, start_cyc, rdb_base, doneb_base;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk100);
        wr_base = wr_n; rd_base = rd_n; done_base = done_n;
        start = 1'b1;
        @(negedge clk100);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Drives the 8 ACQ cycles; call right after pulse_start_a.
    task automatic drive_hits(input logic [7:0] vmask, input logic [15:0] addrs);
        repeat (3) @(negedge clk100);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk100);
            bin_valid = vmask[i];
            bin_addr  = addrs[2*i +: 2];
        end
        @(negedge clk100);
        bin_valid = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int k = 0;
        while (done_n == done_base && k < 100) begin
            @(negedge clk100);
            k++;
        end
        repeat (2) @(negedge clk100);
        check({tag, "_done_count"}, 64'(done_n - done_base), 64'd1);
    endtask

    task automatic check_bins_a(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        check({tag, "_rd_count"}, 64'(rd_n - rd_base), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(rd_addr_log[(rd_base + i) % 64]), 64'(i));
            check($sformatf("%s_bin%0d", tag, i), 64'(rd_data_log[(rd_base + i) % 64]), 64'(e[i]));
        end
    endtask

    task automatic run_b(input int nhits);
        int k = 0;
        @(negedge clk100);
        rdb_base = rdb_n; doneb_base = doneb_n;
        start_b = 1'b1;
        @(negedge clk100);
        start_b = 1'b0;
        check("b_overflow_cleared_on_start", 64'(overflow_b), 64'd0);
        repeat (3) @(negedge clk100);
        for (int i = 0; i < nhits; i++) begin
            @(negedge clk100);
            bin_valid = 1'b1;
            bin_addr  = 2'd0;
        end
        @(negedge clk100);
        bin_valid = 1'b0;
        while (doneb_n == doneb_base && k < 100) begin
            @(negedge clk100);
            k++;
        end
        repeat (2) @(negedge clk100);
        check("b_done_count", 64'(doneb_n - doneb_base), 64'd1);
        check("b_rd_count", 64'(rdb_n - rdb_base), 64'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        // Reset state
        repeat (3) @(negedge clk100);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_overflow", 64'(overflow_a), 64'd0);
        check("rst_rd_valid", 64'(rd_valid_a), 64'd0);
        check("rst_wb_en", 64'(wb_en_a), 64'd0);
        check("rst_ra_en", 64'(ra_en_a), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk100);

        // Basic run: no hits
        pulse_start_a();
        check("basic_busy", 64'(busy_a), 64'd1);
        drive_hits(8'h00, 16'h0000);
        wait_done_a("basic");
        check("basic_clear_writes", 64'(wr_n - wr_base), 64'd4);
        check_bins_a("basic", 32'd0, 32'd0, 32'd0, 32'd0);
        d = done_cyc - start_cyc;
        check($sformatf("basic_start_to_done_%0d_in_17_19", d), 64'(d >= 17 && d <= 19), 64'd1);
        check("basic_done_after_last_rd", 64'(done_cyc - rd_last_cyc), 64'd1);
        check("basic_idle_after", 64'(busy_a), 64'd0);

        // Eight back-to-back hits to bin 2
        pulse_start_a();
        drive_hits(8'hFF, 16'hAAAA);
        wait_done_a("same");
        check("same_writes", 64'(wr_n - wr_base), 64'd12);
        check_bins_a("same", 32'd0, 32'd0, 32'd8, 32'd0);
        check("same_overflow", 64'(overflow_a), 64'd0);

        // Mixed stream 1,1,3,1,0,3 ending on the last ACQ cycle
        pulse_start_a();
        drive_hits(8'hFC, 16'hC750);
        wait_done_a("mixed");
        check("mixed_writes", 64'(wr_n - wr_base), 64'd10);
        check_bins_a("mixed", 32'd1, 32'd3, 32'd0, 32'd2);
        check("mixed_overflow", 64'(overflow_a), 64'd0);

        // Saturation on the 4-bit instance, then overflow clears on the next start
        run_b(20);
        check("sat_bin0", 64'(rdb_data[0]), 64'd15);
        check("sat_bin1", 64'(rdb_data[1]), 64'd0);
        check("sat_bin3", 64'(rdb_data[3]), 64'd0);
        check("sat_overflow", 64'(overflow_b), 64'd1);
        check("sat_a_untouched", 64'(done_n - done_base), 64'd1);
        run_b(0);
        check("sat2_bin0", 64'(rdb_data[0]), 64'd0);
        check("sat2_overflow", 64'(overflow_b), 64'd0);

        // Abort in ACQ after 3 hits to bin 1
        pulse_start_a();
        repeat (3) @(negedge clk100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk100);
            bin_valid = 1'b1;
            bin_addr  = 2'd1;
        end
        @(negedge clk100);
        bin_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk100);
        abort = 1'b0;
        repeat (6) @(negedge clk100);
        check("abort_idle", 64'(busy_a), 64'd0);
        check("abort_no_done", 64'(done_n - done_base), 64'd0);
        check("abort_no_rd", 64'(rd_n - rd_base), 64'd0);
        check("abort_writes", 64'(wr_n - wr_base), 64'd7);
        pulse_start_a();
        drive_hits(8'h00, 16'h0000);
        wait_done_a("post_abort");
        check_bins_a("post_abort", 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset in the middle of READOUT, with start and hits held during reset
        pulse_start_a();
        repeat (14) @(negedge clk100);
        check("mid_readout_busy", 64'(busy_a), 64'd1);
        reset = 1'b0;
        start = 1'b1;
        bin_valid = 1'b1;
        bin_addr = 2'd0;
        done_base = done_n;
        wr_base = wr_n;
        @(negedge clk100);
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_rd_valid", 64'(rd_valid_a), 64'd0);
        check("midrst_rd_data", 64'(rd_data_a), 64'd0);
        check("midrst_ra_en", 64'(ra_en_a), 64'd0);
        check("midrst_wb_en", 64'(wb_en_a), 64'd0);
        check("midrst_wb_din", 64'(wb_din_a), 64'd0);
        check("midrst_done", 64'(done_a), 64'd0);
        @(negedge clk100);
        reset = 1'b1;
        start = 1'b0;
        bin_valid = 1'b0;
        @(negedge clk100);
        check("postrst_busy", 64'(busy_a), 64'd0);
        repeat (10) @(negedge clk100);
        check("postrst_no_done", 64'(done_n - done_base), 64'd0);
        check("postrst_no_writes", 64'(wr_n - wr_base), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_hist_ctrl.md
Name: tdc_hist_ctrl

Overview:
- Sequencer for the TDC histogram memory (dual-port BRAM, 2^ADDR_W bins of DATA_W bits).
- Owns both BRAM ports and steps through four phases: clear all bins, accumulate decoder hits for a fixed window, drain the pipeline, then stream the histogram out.
- Replaces free-running read-modify-write increments with a controlled, hazard-free increment pipeline.
- Sits between the decoder (bin_valid/bin_addr) and the histogram BRAM.

Parameters:
- ADDR_W, 2, bin address width; number of bins is 2^ADDR_W.
- DATA_W, 32, bin counter width.
- ACQ_CYCLES, 1000, length of the acquisition window in clk100 cycles (≥1).

Ports:
- clk100  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  1-cycle pulse; begins a run when in IDLE, ignored otherwise.
- abort  in  1  level; terminates the current run.
- bin_valid  in  1  decoder hit strobe, one hit per cycle max.
- bin_addr  in  ADDR_W  decoder bin index, qualified by bin_valid.
- ra_en  out  1  BRAM port A enable (read only).
- ra_addr  out  ADDR_W  port A address.
- ra_dout  in  DATA_W  port A read data; valid 1 cycle after ra_en.
- wb_en  out  1  BRAM port B enable.
- wb_we  out  1  port B write enable.
- wb_addr  out  ADDR_W  port B address.
- wb_din  out  DATA_W  port B write data.
- busy  out  1  high in every state except IDLE.
- rd_valid  out  1  readout data strobe.
- rd_addr  out  ADDR_W  bin index of rd_data.
- rd_data  out  DATA_W  bin count.
- done  out  1  1-cycle pulse at the end of a completed run.
- overflow  out  1  sticky; a bin saturated during the current run.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE. All outputs 0, including overflow and pipeline registers. BRAM contents untouched. Reset mid-run abandons the run without a done pulse.
- States: IDLE, CLEAR, ACQ, DRAIN, READOUT, FIN.
- IDLE: on start, clear overflow and go to CLEAR.
- CLEAR: write 0 to addresses 0..2^ADDR_W-1, one per cycle (wb_en=wb_we=1), then go to ACQ. Takes exactly 2^ADDR_W cycles.
- ACQ:
  - Window counter runs ACQ_CYCLES cycles; hits are accepted only in these cycles.
  - Hit at cycle t: ra_en=1, ra_addr=bin_addr at t.
  - At t+1: wb_en=wb_we=1, wb_addr=captured addr, wb_din=base+1, where base=ra_dout.
  - Forwarding: if a write to the same addr occurred at cycle t, base is that write's data, not ra_dout.
  - This sustains back-to-back hits to the same bin at 1 hit/cycle with no lost counts.
  - Saturation: if base = 2^DATA_W-1, write base unchanged and set overflow.
  - After the last window cycle, go to DRAIN.
- DRAIN: 1 cycle; completes the pending write of the last-cycle hit. Hits here are ignored. Then go to READOUT, or IDLE if abort is asserted.
- READOUT:
  - Read bins 0..2^ADDR_W-1 on port A, one per cycle.
  - rd_valid=1 one cycle after each read, with rd_addr and rd_data=ra_dout.
  - Exactly 2^ADDR_W rd_valid pulses, in ascending address order.
  - After the last pulse, go to FIN.
- FIN: done=1 for 1 cycle, then IDLE.
- bin_valid outside ACQ: ignored, with no memory access.
- abort:
  - In CLEAR, READOUT or FIN: go to IDLE next cycle; no done pulse.
  - In ACQ: stop accepting hits and go to DRAIN, then IDLE; no done pulse.
- start while busy: ignored.
- Port B is never written outside CLEAR/ACQ/DRAIN. Port A is never enabled in IDLE.

Test Plan:
- Basic run (ADDR_W=2, ACQ_CYCLES=8): start, no hits → 4 clear writes, readout of 4 rd_valid pulses all 0, done 1 cycle after the last pulse. Total from start to done = 4+8+1+4+1 cycles ±1.
- Back-to-back same bin: 8 consecutive hits to bin 2 → readout bin 2 = 8, others = 0, overflow=0.
- Mixed/alternating stream: bins 1,1,3,1,0,3 in consecutive cycles → counts [1,3,0,2]. Hit on the last ACQ cycle is counted.
- Saturation (DATA_W=4): 20 hits to bin 0 → bin 0 = 15, overflow=1. overflow clears on the next start.
- Abort in ACQ after 3 hits → DRAIN then IDLE, no done, no rd_valid. A following start clears the bins: readout all 0.
- Reset mid-READOUT → outputs 0, state IDLE. Hits and start during reset are ignored. busy=0 the cycle after reset.
